// File: rtl/mult_serial_collector.sv
// Serial-to-parallel collector for the bit-serial multiplier product stream.
// Assembles PW=2*N serial bits into a holding register presented via valid/ready.
module mult_serial_collector #(
  parameter int N         = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           START,
  input  logic           O_IN,
  input  logic           OUT_READY,
  output logic [2*N-1:0] P,
  output logic           P_VALID,
  output logic           BUSY,
  output logic           OVERRUN
);
  localparam int PW = 2 * N;
  localparam int CW = (PW > 2) ? $clog2(PW) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state;
  logic [PW-1:0] sr;
  logic [CW-1:0] count;

  logic [PW-1:0] word;
  logic [CW-1:0] idx;
  logic [CW-1:0] pos;
  logic          complete;

  // A START always begins a fresh word, so the base is cleared rather than
  // taken from the shift register; this also makes restart win over completion.
  always_comb begin
    word = START ? '0 : sr;
    idx  = START ? '0 : count;
    pos  = LSB_FIRST ? idx : CW'(PW - 1) - idx;
    word[pos] = O_IN;
    complete = (state == SHIFT) && !START && (count == CW'(PW - 1));
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= IDLE;
      sr      <= '0;
      count   <= '0;
      P       <= '0;
      P_VALID <= 1'b0;
      BUSY    <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      if (complete) begin
        if (!P_VALID || OUT_READY) begin
          P       <= word;
          P_VALID <= 1'b1;
        end else begin
          OVERRUN <= 1'b1;
        end
      end else if (P_VALID && OUT_READY) begin
        P_VALID <= 1'b0;
      end

      if (START) begin
        sr    <= word;
        count <= CW'(1);
        state <= SHIFT;
        BUSY  <= 1'b1;
      end else if (state == SHIFT) begin
        if (complete) begin
          count <= '0;
          state <= IDLE;
          BUSY  <= 1'b0;
        end else begin
          sr    <= word;
          count <= count + 1'b1;
        end
      end
    end
  end
endmodule
